// File: rtl/hamming_15_11_serial_enc_pkg.sv
// Shared constants, FSM state type and LFSR step for the cyclic Hamming (15,11) code.
// Used by both the serial encoder and the matching decoder.
package hamming_15_11_serial_enc_pkg;

  localparam int unsigned MSG_W = 11;
  localparam int unsigned CW_W  = 15;
  localparam int unsigned PAR_W = 4;
  localparam int unsigned CNT_W = 4;

  // g(x) = x^4 + x + 1; the low taps are what the LFSR feeds back into
  localparam logic [PAR_W:0]   GEN_POLY = 5'b10011;
  localparam logic [PAR_W-1:0] GEN_TAPS = GEN_POLY[PAR_W-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  // One division step of the remainder register by g(x), input entering premultiplied by x^4
  function automatic logic [PAR_W-1:0] lfsr_step(input logic [PAR_W-1:0] r, input logic b);
    logic fb;
    fb = b ^ r[PAR_W-1];
    return {r[PAR_W-2:0], 1'b0} ^ (fb ? GEN_TAPS : PAR_W'(0));
  endfunction

endpackage

// File: rtl/hamming_15_11_serial_enc_if.sv
// Message-in / codeword-out handshake bundle for the Hamming (15,11) encoder.
// With HAMMING_ENC_ERR_INJ_EN defined the bundle carries an error vector as well.
interface hamming_15_11_serial_enc_if;
  import hamming_15_11_serial_enc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [MSG_W-1:0] msg;
  logic             out_valid;
  logic             out_ready;
  logic [CW_W-1:0]  codeword;
`ifdef HAMMING_ENC_ERR_INJ_EN
  logic [CW_W-1:0]  err_vec;
`endif

  modport master (
`ifdef HAMMING_ENC_ERR_INJ_EN
    output err_vec,
`endif
    output in_valid, msg, out_ready,
    input  in_ready, out_valid, codeword
  );

  modport slave (
`ifdef HAMMING_ENC_ERR_INJ_EN
    input  err_vec,
`endif
    input  in_valid, msg, out_ready,
    output in_ready, out_valid, codeword
  );

endinterface

// File: rtl/hamming_lfsr4.sv
// 4-bit remainder register dividing a serial bit stream by g(x) = x^4 + x + 1.
// rem_next_c is the remainder including the bit currently presented on din.
module hamming_lfsr4
  import hamming_15_11_serial_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [PAR_W-1:0] rem_next_c
);

  logic [PAR_W-1:0] rem_q;
  logic [PAR_W-1:0] rem_d;

  always_comb begin
    rem_next_c = lfsr_step(rem_q, din);
    rem_d      = rem_q;
    if (clr) begin
      rem_d = '0;
    end else if (shift_en) begin
      rem_d = rem_next_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/hamming_15_11_serial_enc.sv
// Serial systematic Hamming (15,11) encoder: one message bit per cycle through the LFSR.
// Define HAMMING_ENC_ERR_INJ_EN to XOR a captured err_vec into the presented codeword.
module hamming_15_11_serial_enc
  import hamming_15_11_serial_enc_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  hamming_15_11_serial_enc_if.slave   bus
);

  enc_state_e       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [MSG_W-1:0] msg_sr_q,    msg_sr_d;
  logic [MSG_W-1:0] msg_hold_q,  msg_hold_d;
  logic [CW_W-1:0]  codeword_q,  codeword_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q,  in_ready_d;
  logic [CW_W-1:0]  err_q,       err_d;
  logic             lfsr_clr;
  logic             lfsr_shift;
  logic [PAR_W-1:0] rem_next;

  hamming_lfsr4 u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .clr        (lfsr_clr),
    .shift_en   (lfsr_shift),
    .din        (msg_sr_q[MSG_W-1]),
    .rem_next_c (rem_next)
  );

  // Next-state, datapath and handshake decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    msg_sr_d    = msg_sr_q;
    msg_hold_d  = msg_hold_q;
    codeword_d  = codeword_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    lfsr_clr    = 1'b0;
    lfsr_shift  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          msg_sr_d   = bus.msg;
          msg_hold_d = bus.msg;
          cnt_d      = '0;
          lfsr_clr   = 1'b1;
`ifdef HAMMING_ENC_ERR_INJ_EN
          err_d      = bus.err_vec;
`else
          err_d      = '0;
`endif
          state_d    = ENC;
        end
      end
      ENC: begin
        lfsr_shift = 1'b1;
        msg_sr_d   = {msg_sr_q[MSG_W-2:0], 1'b0};
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MSG_W - 1)) begin
          cnt_d       = '0;
          codeword_d  = {msg_hold_q, rem_next} ^ err_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      msg_sr_q    <= '0;
      msg_hold_q  <= '0;
      codeword_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      msg_sr_q    <= msg_sr_d;
      msg_hold_q  <= msg_hold_d;
      codeword_q  <= codeword_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.codeword  = codeword_q;

endmodule

// File: tb/tb_hamming_15_11_serial_enc.sv
// Directed bench for the serial Hamming (15,11) encoder with a polynomial-division reference.
// Define HAMMING_ENC_ERR_INJ_EN to also exercise the error-injection path.
module tb_hamming_15_11_serial_enc;
  import hamming_15_11_serial_enc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  hamming_15_11_serial_enc_if bus ();

  hamming_15_11_serial_enc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remainder of a 15-bit polynomial mod x^4+x+1 by long division
  function automatic logic [3:0] poly_rem(input logic [14:0] w);
    logic [14:0] r;
    logic [14:0] g;
    r = w;
    g = 15'b000_0000_0001_0011;
    for (int i = 14; i >= 4; i--) begin
      if (r[i]) r = r ^ (g << (i - 4));
    end
    return r[3:0];
  endfunction

  function automatic logic [14:0] ref_enc(input logic [10:0] m);
    return {m, poly_rem({m, 4'b0000})};
  endfunction

  // Accept one message, check latency and codeword, optionally stall in DONE, then hand off
  task automatic run_word(input logic [10:0] m, input logic [14:0] exp, input int stall,
                          input string tag);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ready_seen"}, 32'(n < 50), 32'd1);
    bus.msg      = m;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.msg      = ~m;
    check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check({tag, "_latency"}, 32'(n), 32'd11);
    check({tag, "_codeword"}, 32'(bus.codeword), 32'(exp));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_stall"}, 32'({bus.out_valid, bus.in_ready, bus.codeword}),
            32'({1'b1, 1'b0, exp}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_handoff"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
  endtask

  initial begin
    logic [10:0] m;
    logic [14:0] exp;
    int          n;
    int          cyc;
    int          last;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.msg       = '0;
`ifdef HAMMING_ENC_ERR_INJ_EN
    bus.err_vec   = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset_state", 32'({bus.in_ready, bus.out_valid, bus.codeword}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", 32'({bus.in_ready, bus.out_valid}), 32'b10);

    run_word(11'h001, 15'h0013, 0, "msg001");
    run_word(11'h400, 15'h4009, 0, "msg400");
    run_word(11'h000, 15'h0000, 0, "msg000");
    run_word(11'h7FF, 15'h7FFF, 0, "msg7ff");
    run_word(11'h555, ref_enc(11'h555), 20, "backpressure");

    // Abort a word five cycles into encoding
    bus.msg      = 11'h2AB;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_in_reset", 32'({bus.in_ready, bus.out_valid, bus.codeword}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_released", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    run_word(11'h001, 15'h0013, 0, "after_abort");

`ifdef HAMMING_ENC_ERR_INJ_EN
    bus.err_vec = 15'h0001;
    run_word(11'h001, 15'h0012, 0, "err_inj");
    check("err_inj_syndrome", 32'(poly_rem(bus.codeword)), 32'd1);
    bus.err_vec = '0;
`endif

    // Back-to-back random words with in_valid and out_ready held high
    m             = 11'($urandom_range(0, 2047));
    exp           = ref_enc(m);
    bus.msg       = m;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    cyc  = 0;
    last = 0;
    for (int w = 0; w < 1000; w++) begin
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; cyc++; end
      check("b2b_seen", 32'(n < 40), 32'd1);
      check("b2b_codeword", 32'(bus.codeword), 32'(exp));
      check("b2b_syndrome", 32'(poly_rem(bus.codeword)), 32'd0);
      if (w > 0) check("b2b_spacing", 32'(cyc - last), 32'd13);
      last    = cyc;
      m       = 11'($urandom_range(0, 2047));
      exp     = ref_enc(m);
      bus.msg = m;
      if (w == 999) bus.in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("final_idle", 32'({bus.in_ready, bus.out_valid}), 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_15_11_serial_enc.md
Name: hamming_15_11_serial_enc

Overview:
- Systematic cyclic Hamming (15,11) encoder. It is the transmit-side counterpart of the pipelined 15-bit decoder.
- Accepts an 11-bit message over a valid/ready handshake.
- Computes 4 parity bits serially with a 4-bit LFSR dividing by g(x)=x^4+x+1, one message bit per cycle.
- Presents the 15-bit codeword over a valid/ready handshake. Its output feeds the channel / decoder input (received-word path).

Parameters:
- MSG_W, 11, message width k (fixed by code; not to be overridden)
- CW_W, 15, codeword width n (fixed by code)
- CNT_W, 4, bit-counter width (ceil log2 MSG_W)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  message available
- in_ready  output  1  encoder can accept a message
- msg  input  11  message; msg[10] = coefficient of x^10, shifted first
- out_valid  output  1  codeword valid
- out_ready  input  1  downstream accepts codeword
- codeword  output  15  {msg[10:0], parity[3:0]}; codeword[14] = x^14 coefficient

Behaviour:
- Clocking and reset: one clock. rst is asynchronous, active-high. While rst is high:
  - state=IDLE, in_ready=0 during reset then 1 once released.
  - out_valid=0, codeword=0, LFSR=0, counter=0.
- FSM states: IDLE, ENC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On edge with in_valid=1: latch msg into shift register and hold copy, LFSR<=0, cnt<=0, go to ENC.
- ENC:
  - in_ready=0. Each edge shifts bit b = msg_sr[10-cnt].
  - fb = b ^ r[3]; r <= {r[2:0],0} ^ (fb ? 4'b0011 : 4'b0000); cnt<=cnt+1.
  - After the edge processing cnt==10 (11th bit), go to DONE and register codeword={msg_hold, r_next}.
- DONE:
  - out_valid=1, codeword stable, in_ready=0.
  - On edge with out_ready=1: go to IDLE, out_valid<=0.
  - out_ready low: hold indefinitely. codeword and out_valid must not change while stalled.
- Latency: accept edge E0. out_valid high after edge E11 (11 cycles after acceptance). in_ready returns after the handshake edge.
- Throughput: minimum one word per 13 cycles (accept, 11 shifts, output handshake). No overlap of input acceptance with DONE.
- in_valid is ignored outside IDLE. msg changes after acceptance do not affect the in-flight word.
- Reset mid-ENC or mid-DONE aborts the word. No partial codeword is ever presented.
- Arithmetic: GF(2) only. Parity = msg(x)*x^4 mod g(x). Counter never wraps beyond 10 in ENC.
- Every emitted codeword has zero syndrome under the matching decoder.

Optional Feature:
- Macro: HAMMING_ENC_ERR_INJ_EN.
- With the macro defined:
  - Adds input err_vec[14:0].
  - err_vec is sampled together with msg on the accept edge.
  - The codeword is presented as {msg,parity} ^ err_vec_held, by bitwise XOR, to exercise the decoder's correction path.
- Without the macro: port absent; codeword is the pure encoding.

Decomposition:
- Shared package: constants CW_W=15, MSG_W=11, PAR_W=4, GEN_POLY=5'b10011 (low taps 4'b0011), and the FSM state enum {IDLE, ENC, DONE}. The decoder uses the same package for n/k and generator.
- One sub-module is natural: hamming_lfsr4. It has clear, shift-enable, serial data in, and 4-bit remainder out. The top holds the FSM, counter, message registers and handshake.

Test Plan:
- msg=11'h001 accepted → after 11 cycles out_valid=1, codeword=15'h0013 (parity 4'b0011).
- msg=11'h400 → codeword=15'h4009; msg=11'h000 → codeword=15'h0000; msg=11'h7FF → codeword=15'h7FFF.
- Backpressure:
  - Hold out_ready=0 for 20 cycles in DONE → codeword/out_valid stable and in_ready=0.
  - Raise out_ready → out_valid drops next edge, in_ready=1.
- Reset:
  - Assert rst 5 cycles after acceptance → out_valid=0, in_ready=1 after release.
  - A new msg=11'h001 → codeword 15'h0013; no residue from the aborted word.
- Back-to-back and randomisation:
  - in_valid held high with out_ready=1 → words accepted every 13 cycles.
  - 1000 random messages, each codeword checked against a reference model and for zero syndrome.
- With HAMMING_ENC_ERR_INJ_EN: msg=11'h001, err_vec=15'h0001 → codeword=15'h0012. Decoder corrects back to 15'h0013.
